// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame controller: FSM state encoding,
// parity-mode constants and the parity-check helper.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam bit PARITY_MODE_EVEN = 1'b1;
  localparam bit PARITY_MODE_ODD  = 1'b0;

  // 1 when data parity plus received parity bit disagree with the selected mode
  function automatic logic parity_error(input logic acc, input logic pbit, input bit even);
    return acc ^ pbit ^ even ^ 1'b1;
  endfunction

endpackage

// File: rtl/parity_accum.sv
// 1-bit serial XOR accumulator: async active-low reset, synchronous clear
// (takes priority over enable), and a per-bit enable.
module parity_accum (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic d,
  output logic acc
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      acc <= 1'b0;
    else if (clear)
      acc <= 1'b0;
    else if (enable)
      acc <= acc ^ d;
  end

endmodule

// File: rtl/parity_frame_ctrl.sv
// Frame controller: sequences DATA_BITS data bits plus one parity bit through
// a serial parity accumulator, flags parity errors and counts errored frames.
module parity_frame_ctrl
  import parity_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter bit          PARITY_EVEN = PARITY_MODE_EVEN,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               in,
  input  logic                               in_valid,
  output logic                               busy,
  output logic                               run_parity,
  output logic [$clog2(DATA_BITS+1)-1:0]     bit_cnt,
  output logic                               frame_done,
  output logic                               parity_err,
  output logic [ERR_CNT_W-1:0]               err_count
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  state_t state_q, state_d;
  logic   acc_clr;
  logic   acc_en;
  logic   par_take;
  logic   err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    par_take = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_clr = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (in_valid) begin
          acc_en = 1'b1;
          if (bit_cnt == LAST_BIT)
            state_d = PARITY;
        end
      end
      PARITY: begin
        if (in_valid) begin
          par_take = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign err        = parity_error(run_parity, in, PARITY_EVEN);

  parity_accum u_accum (
    .clock  (clock),
    .reset  (reset),
    .clear  (acc_clr),
    .enable (acc_en),
    .d      (in),
    .acc    (run_parity)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      bit_cnt <= '0;
    else if (acc_clr)
      bit_cnt <= '0;
    else if (acc_en)
      bit_cnt <= bit_cnt + CNT_W'(1);
  end

  // Error flag survives into IDLE for read-back; only an accepted start clears it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      parity_err <= 1'b0;
      err_count  <= '0;
    end else if (acc_clr) begin
      parity_err <= 1'b0;
    end else if (par_take) begin
      parity_err <= err;
      if (err && (err_count != '1))
        err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule
